// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter
// Two-requester arbiter in front of a single-port on-chip RAM (port A).
// Each cycle, at most one request is granted, using combinational arbitration.
// A granted read returns data exactly one cycle later, tagged to its owner.
// Optional feature: define ONCHIP_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking. Without it, m0 always wins a tie.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // requester 0
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  // requester 1
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  // RAM port A
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int BE_W = DATA_W / 8;

  logic req0_s;
  logic req1_s;
  logic gnt0_s;
  logic gnt1_s;
  logic rd_gnt_s;
  logic pend_r;
  logic owner_r;

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
  logic last_grant_r;
`endif

  assign req0_s = m0_read | m0_write;
  assign req1_s = m1_read | m1_write;

  // Pick at most one requester this cycle; no grant while in reset.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_s && req1_s) begin
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
      // The requester that did not win last time takes the tie.
      if (last_grant_r) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
`else
      gnt0_s = 1'b1;
`endif
    end else if (req0_s) begin
      gnt0_s = 1'b1;
    end else if (req1_s) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Steer the granted requester onto the RAM port. Read+write counts as a write.
  always_comb begin
    mem_address    = {ADDR_W{1'b0}};
    mem_byteenable = {BE_W{1'b0}};
    mem_writedata  = {DATA_W{1'b0}};
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    rd_gnt_s       = 1'b0;
    case ({gnt1_s, gnt0_s})
      2'b01: begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        mem_chipselect = 1'b1;
        mem_write      = m0_write;
        rd_gnt_s       = m0_read & ~m0_write;
      end
      2'b10: begin
        mem_address    = m1_address;
        mem_byteenable = m1_byteenable;
        mem_writedata  = m1_writedata;
        mem_chipselect = 1'b1;
        mem_write      = m1_write;
        rd_gnt_s       = m1_read & ~m1_write;
      end
      default: begin
        mem_address    = {ADDR_W{1'b0}};
        mem_byteenable = {BE_W{1'b0}};
        mem_writedata  = {DATA_W{1'b0}};
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        rd_gnt_s       = 1'b0;
      end
    endcase
  end

  assign mem_clken = 1'b1;

  // Idle requesters are never stalled; everyone is stalled during reset.
  assign m0_waitrequest = reset | (req0_s & ~gnt0_s);
  assign m1_waitrequest = reset | (req1_s & ~gnt1_s);

  // Track the one outstanding read and which requester owns it.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r  <= 1'b0;
      owner_r <= 1'b0;
    end else begin
      pend_r <= rd_gnt_s;
      if (rd_gnt_s) begin
        owner_r <= gnt1_s;
      end
    end
  end

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
  // Remember the most recent winner so ties alternate; m0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= 1'b1;
    end else if (gnt0_s || gnt1_s) begin
      last_grant_r <= gnt1_s;
    end
  end
`endif

  // RAM data goes straight to both requesters. The valid strobe is masked by
  // reset, so a read that is in flight when reset arrives is dropped.
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = pend_r & ~owner_r & ~reset;
  assign m1_readdatavalid = pend_r &  owner_r & ~reset;

endmodule

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, word-address width of the shared single-port RAM.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mN_address  input  ADDR_W  requester N word address; N = 0, 1 throughout.
REQ-006 mN_read / mN_write  input  1 each  requester N read / write request.
REQ-007 mN_byteenable  input  DATA_W/8  requester N byte lanes.
REQ-008 mN_writedata  input  DATA_W  requester N write data.
REQ-009 mN_waitrequest  output  1  high = requester N's request not accepted this cycle.
REQ-010 mN_readdata  output  DATA_W  read data returned to requester N.
REQ-011 mN_readdatavalid  output  1  one-cycle strobe qualifying mN_readdata.
REQ-012 mem_address, mem_byteenable, mem_writedata  output  ADDR_W, DATA_W/8, DATA_W  RAM port-A drive.
REQ-013 mem_chipselect / mem_write / mem_clken  output  1 each  RAM select, write strobe, clock enable.
REQ-014 mem_readdata  input  DATA_W  RAM output; valid exactly one clk after the address cycle.

Function
REQ-015 Arbitration is evaluated combinationally each cycle; exactly one request, or none, is granted per cycle.
REQ-016 The granted requester sees mN_waitrequest low in that same cycle; a non-granted requester with a pending request sees it high.
REQ-017 With no request pending, both mN_waitrequest outputs are low, so idle masters are never stalled.
REQ-018 The granted requester's address, byteenable and writedata drive the mem_* port in the grant cycle, with mem_chipselect = 1.
REQ-019 mem_write = 1 only for a granted write; mem_chipselect = 0 and mem_write = 0 on idle cycles.
REQ-020 mem_clken is held at 1.
REQ-021 If one requester asserts read and write together, the request is treated as a write and the read is dropped (no readdatavalid).
REQ-022 A granted read sets a registered pending flag and owner ID.
REQ-023 On the following cycle, the owner's mN_readdatavalid = 1 and mN_readdata = mem_readdata; the other requester's readdatavalid = 0.
REQ-024 Read latency is fixed at 1 cycle.
REQ-025 Back-to-back grants (reads and/or writes) are accepted every cycle with no bubbles.
REQ-026 A write followed by a read to the same address in the next cycle returns the newly written data.
REQ-027 mN_readdata outputs mem_readdata unconditionally; it is qualified only by readdatavalid.
REQ-028 A registered last_grant bit records the most recently granted requester.
REQ-029 last_grant updates only on cycles in which a grant occurs.

Reset
REQ-030 While reset = 1, the pending flag clears and last_grant = 1, so m0 wins the first tie after reset.
REQ-031 While reset = 1, both readdatavalid outputs are 0, both waitrequest outputs are 1, and mem_chipselect = mem_write = 0.
REQ-032 If reset is asserted in the cycle after a read grant, that read's readdatavalid is suppressed.
REQ-033 Reset completes in a single cycle; requests are accepted in the first cycle after reset deasserts.

Configuration
REQ-034 Macro ONCHIP_ARB_ROUND_ROBIN_EN is defined: when both requesters request simultaneously, the requester that is not last_grant wins.
REQ-035 Macro ONCHIP_ARB_ROUND_ROBIN_EN is not defined: fixed priority applies, m0 always wins ties, and last_grant logic is compiled out.
REQ-036 All other behaviour is identical with and without ONCHIP_ARB_ROUND_ROBIN_EN.

Verification
REQ-037 m0 write addr 0x0010 data 0xDEADBEEF be 0xF, then m1 read 0x0010 -> m1_readdatavalid 1 cycle after the read grant, m1_readdata 0xDEADBEEF.
REQ-038 m0 and m1 both read continuously for 6 cycles (RR enabled) -> grants alternate m0,m1,m0,m1,m0,m1 and each readdatavalid goes to the correct owner.
REQ-039 Same stimulus as REQ-038 with RR disabled -> m0 granted all 6 cycles and m1_waitrequest held high throughout.
REQ-040 Byte write be 0x2 data 0x0000AB00 over 0x11223344, then read back -> 0x1122AB44.
REQ-041 m1 read granted at cycle T, reset = 1 at T+1 -> no readdatavalid at T+1; after reset, a simultaneous m0/m1 request grants m0 first.
REQ-042 m0 asserts read and write together to 0x7FFF -> write performed, and no m0_readdatavalid on the next cycle.
